rx_cmd_decoder: RTL and testbench

//  Consumes bytes from the UART receiver and assembles them into command frames.

---
 rtl/rx_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_decoder.sv
// Command-frame decoder behind the UART receiver: assembles opcode/operand bytes
// into register-write, register-read and ALU strobes, aborting frames on bad bytes or stalls.
module rx_cmd_decoder #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 4,
    parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
    parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
    parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
    parameter logic [15:0]       TIMEOUT     = 16'd0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              par_err,
    input  logic              stp_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic              frame_err,
    output logic              cmd_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              alu_en_q, alu_en_d;
    logic              frame_err_q, frame_err_d;
    logic              cmd_err_q, cmd_err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [3:0]        alu_fun_q, alu_fun_d;

    logic byte_ok;
    logic byte_bad;
    logic is_opcode;
    logic timeout_hit;

    assign byte_ok   = rx_valid && !par_err && !stp_err;
    assign byte_bad  = rx_valid && (par_err || stp_err);
    assign is_opcode = (rx_data == CMD_WR) || (rx_data == CMD_RD) ||
                       (rx_data == CMD_ALU_OP) || (rx_data == CMD_ALU_NOP);
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 16'd0) && (state_q != S_IDLE) &&
                         !rx_valid && (timer_q == TIMEOUT);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            alu_fun_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            alu_en_q    <= alu_en_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            alu_fun_q   <= alu_fun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        if (byte_bad || timeout_hit) begin
            state_d = S_IDLE;
        end else if (byte_ok) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == CMD_WR)           state_d = S_WR_ADDR;
                    else if (rx_data == CMD_RD)      state_d = S_RD_ADDR;
                    else if (rx_data == CMD_ALU_OP)  state_d = S_OP_A;
                    else if (rx_data == CMD_ALU_NOP) state_d = S_ALU_FUN;
                end
                S_WR_ADDR: state_d = S_WR_DATA;
                S_WR_DATA: state_d = S_IDLE;
                S_RD_ADDR: state_d = S_IDLE;
                S_OP_A:    state_d = S_OP_B;
                S_OP_B:    state_d = S_ALU_FUN;
                S_ALU_FUN: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
        if (TIMEOUT != 16'd0 && state_q != S_IDLE && !rx_valid && !timeout_hit) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        cmd_err_d   = 1'b0;
        frame_err_d = byte_bad || timeout_hit;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        alu_fun_d   = alu_fun_q;
        busy_d      = (state_d != S_IDLE);
        if (byte_ok && !timeout_hit) begin
            case (state_q)
                S_IDLE:    cmd_err_d = !is_opcode;
                S_WR_ADDR: addr_d = rx_data[ADDR_W-1:0];
                S_WR_DATA: begin
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                end
                S_RD_ADDR: begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    rd_en_d = 1'b1;
                end
                // Operands with the ALU opcode land in registers 0 and 1.
                S_OP_A: begin
                    addr_d    = '0;
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                end
                S_OP_B: begin
                    addr_d    = ADDR_W'(1);
                    wr_data_d = rx_data;
                    wr_en_d   = 1'b1;
                end
                S_ALU_FUN: begin
                    alu_fun_d = rx_data[3:0];
                    alu_en_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign alu_en    = alu_en_q;
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = busy_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign alu_fun   = alu_fun_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Bench for rx_cmd_decoder: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized byte streams.
module tb_rx_cmd_decoder;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       RST;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       par_err;
    logic       stp_err;
    logic       wr_en, rd_en, alu_en, frame_err, cmd_err, busy;
    logic [3:0] addr;
    logic [7:0] wr_data;
    logic [3:0] alu_fun;

    rx_cmd_decoder #(.TIMEOUT(16'(TMO))) dut (
        .clk(clk), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
        .par_err(par_err), .stp_err(stp_err),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .alu_en(alu_en), .alu_fun(alu_fun), .frame_err(frame_err),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bytes of the open frame, and cycle of the last byte.
    logic [7:0] q[$];
    int         t = 0;
    int         last_rx = 0;
    logic       e_wr_en = 0, e_rd_en = 0, e_alu_en = 0, e_frame_err = 0, e_cmd_err = 0, e_busy = 0;
    logic [3:0] e_addr = 0, e_alu_fun = 0;
    logic [7:0] e_wr_data = 0;

    task automatic accept(logic [7:0] b);
        if (q.size() == 0) begin
            if (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) q.push_back(b);
            else e_cmd_err = 1;
        end else begin
            q.push_back(b);
            case (q[0])
                8'hAA: begin
                    if (q.size() == 2) e_addr = b[3:0];
                    else begin e_wr_data = b; e_wr_en = 1; q.delete(); end
                end
                8'hBB: begin e_addr = b[3:0]; e_rd_en = 1; q.delete(); end
                8'hCC: begin
                    if (q.size() == 2) begin e_addr = 4'd0; e_wr_data = b; e_wr_en = 1; end
                    else if (q.size() == 3) begin e_addr = 4'd1; e_wr_data = b; e_wr_en = 1; end
                    else begin e_alu_fun = b[3:0]; e_alu_en = 1; q.delete(); end
                end
                8'hDD: begin e_alu_fun = b[3:0]; e_alu_en = 1; q.delete(); end
                default: q.delete();
            endcase
        end
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_step();
        t++;
        e_wr_en = 0; e_rd_en = 0; e_alu_en = 0; e_frame_err = 0; e_cmd_err = 0;
        if (!RST) begin
            q.delete();
            e_addr = 0; e_wr_data = 0; e_alu_fun = 0; e_busy = 0;
            last_rx = t;
            return;
        end
        if (rx_valid) begin
            last_rx = t;
            if (par_err || stp_err) begin e_frame_err = 1; q.delete(); end
            else accept(rx_data);
        end else if (q.size() != 0 && (t - last_rx) == TMO + 1) begin
            // TMO idle cycles have elapsed and the next one still brings no byte.
            e_frame_err = 1;
            q.delete();
        end
        e_busy = (q.size() != 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", 32'(wr_en), 32'(e_wr_en));
            check("rd_en", 32'(rd_en), 32'(e_rd_en));
            check("alu_en", 32'(alu_en), 32'(e_alu_en));
            check("frame_err", 32'(frame_err), 32'(e_frame_err));
            check("cmd_err", 32'(cmd_err), 32'(e_cmd_err));
            check("busy", 32'(busy), 32'(e_busy));
            check("addr", 32'(addr), 32'(e_addr));
            check("wr_data", 32'(wr_data), 32'(e_wr_data));
            check("alu_fun", 32'(alu_fun), 32'(e_alu_fun));
        end
    end

    // Strobe monitor used by the directed literal checks.
    int          wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, fe_cnt = 0, ce_cnt = 0;
    logic [11:0] wr_log[$];
    logic [3:0]  rd_addr_last = 0;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin wr_cnt++; wr_log.push_back({addr, wr_data}); end
        if (rd_en === 1'b1) begin rd_cnt++; rd_addr_last = addr; end
        if (alu_en === 1'b1) alu_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (cmd_err === 1'b1) ce_cnt++;
    end

    // Inputs change at negedge+2; the task returns at the next negedge+2.
    task automatic drive(logic v, logic [7:0] d, logic pe, logic se);
        rx_valid = v; rx_data = d; par_err = pe; stp_err = se;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic send(logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, a0, f0, c0, lb;
        RST = 1'b1; rx_valid = 0; rx_data = 0; par_err = 0; stp_err = 0;
        #1 RST = 1'b0;
        #1;
        check("reset wr_en", 32'(wr_en), 0);
        check("reset rd_en", 32'(rd_en), 0);
        check("reset alu_en", 32'(alu_en), 0);
        check("reset busy", 32'(busy), 0);
        check("reset addr", 32'(addr), 0);
        check("reset wr_data", 32'(wr_data), 0);
        check("reset alu_fun", 32'(alu_fun), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset cmd_err", 32'(cmd_err), 0);
        @(negedge clk); #2;
        chk_en = 1;
        idle(2);
        RST = 1'b1;
        idle(2);

        w0 = wr_cnt; r0 = rd_cnt;
        send(8'hAA); send(8'h05); send(8'h3C); idle(3);
        check("AA wr count", 32'(wr_cnt - w0), 1);
        check("AA wr addr/data", 32'(wr_log[wr_log.size()-1]), 32'h53C);
        check("AA rd count", 32'(rd_cnt - r0), 0);
        check("AA busy after", 32'(busy), 0);

        w0 = wr_cnt; r0 = rd_cnt; a0 = alu_cnt;
        send(8'hBB); send(8'h0A); idle(2);
        check("BB rd count", 32'(rd_cnt - r0), 1);
        check("BB rd addr", 32'(rd_addr_last), 32'hA);
        check("BB wr count", 32'(wr_cnt - w0), 0);
        check("BB alu count", 32'(alu_cnt - a0), 0);

        w0 = wr_cnt; a0 = alu_cnt; lb = wr_log.size();
        send(8'hCC); send(8'h12); send(8'h34); send(8'h02); idle(2);
        check("CC wr count", 32'(wr_cnt - w0), 2);
        check("CC opA", 32'(wr_log[lb]), 32'h012);
        check("CC opB", 32'(wr_log[lb+1]), 32'h134);
        check("CC alu count", 32'(alu_cnt - a0), 1);
        check("CC alu_fun", 32'(alu_fun), 2);

        w0 = wr_cnt; f0 = fe_cnt; r0 = rd_cnt;
        send(8'hAA); send(8'h03); drive(1'b1, 8'h77, 1'b1, 1'b0); idle(2);
        check("parity frame_err", 32'(fe_cnt - f0), 1);
        check("parity no wr", 32'(wr_cnt - w0), 0);
        send(8'hBB); send(8'h03); idle(2);
        check("after abort rd", 32'(rd_cnt - r0), 1);
        check("after abort addr", 32'(rd_addr_last), 3);

        f0 = fe_cnt; c0 = ce_cnt;
        send(8'hAA); idle(25);
        check("timeout frame_err", 32'(fe_cnt - f0), 1);
        check("timeout busy", 32'(busy), 0);
        send(8'h7E); idle(1);
        check("7E cmd_err", 32'(ce_cnt - c0), 1);

        f0 = fe_cnt; w0 = wr_cnt;
        send(8'hAA); idle(TMO); send(8'h05); send(8'h3C); idle(2);
        check("edge no timeout", 32'(fe_cnt - f0), 0);
        check("edge wr count", 32'(wr_cnt - w0), 1);

        f0 = fe_cnt; c0 = ce_cnt;
        drive(1'b1, 8'h7E, 1'b0, 1'b1); idle(1);
        check("idle stop err frame_err", 32'(fe_cnt - f0), 1);
        check("idle stop err no cmd_err", 32'(ce_cnt - c0), 0);

        send(8'hCC); send(8'h11);
        RST = 1'b0;
        #1;
        check("async rst wr_en", 32'(wr_en), 0);
        check("async rst addr", 32'(addr), 0);
        check("async rst wr_data", 32'(wr_data), 0);
        check("async rst busy", 32'(busy), 0);
        w0 = wr_cnt;
        idle(2);
        RST = 1'b1;
        a0 = alu_cnt;
        send(8'hDD); send(8'h05); idle(2);
        check("post rst no wr", 32'(wr_cnt - w0), 0);
        check("post rst alu count", 32'(alu_cnt - a0), 1);
        check("post rst alu_fun", 32'(alu_fun), 5);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                idle($urandom_range(TMO - 5, TMO + 4));
            end else if (r < 4) begin
                RST = 1'b0;
                idle($urandom_range(1, 2));
                RST = 1'b1;
            end else if (r < 55) begin
                logic [7:0] d;
                if ($urandom_range(0, 1) == 0) d = 8'hAA + 8'(17 * $urandom_range(0, 3));
                else d = 8'($urandom);
                drive(1'b1, d, ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
            end else begin
                idle(1);
            end
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
